// File: rtl/uart_parity_pkg.sv
// Shared types and helpers for the UART parity engine (TX generator + RX checker).
package uart_parity_pkg;

  localparam int MIN_DATA_LEN = 5;

  typedef enum logic [1:0] {
    EVEN  = 2'd0,
    ODD   = 2'd1,
    MARK  = 2'd2,
    SPACE = 2'd3
  } parity_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } rx_chk_state_e;

  // acc is the XOR of the data bits; returns the parity bit the line should carry
  function automatic logic parity_calc(input parity_mode_e mode, input logic acc);
    logic r;
    case (mode)
      EVEN:    r = acc;
      ODD:     r = ~acc;
      MARK:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_parity_rx_chk.sv
// Serial RX parity checker: accumulates data bits of a frame and compares the parity bit.
module uart_parity_rx_chk
  import uart_parity_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_parity_en,
  input  logic [1:0]       i_parity_mode,
  input  logic [LEN_W-1:0] i_len_eff,
  input  logic             i_rx_frame_start,
  input  logic             i_rx_bit_valid,
  input  logic             i_rx_bit,
  output logic             o_chk,
  output logic             o_mis,
  output logic             o_parity_err,
  output logic             o_err_valid
);

  rx_chk_state_e r_state, w_state_nxt;
  parity_mode_e  r_mode,  w_mode_nxt;
  logic [LEN_W-1:0] r_len, w_len_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_acc, w_acc_nxt;
  logic             r_parity_err, r_err_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_mode       <= EVEN;
      r_len        <= '0;
      r_cnt        <= '0;
      r_acc        <= 1'b0;
      r_parity_err <= 1'b0;
      r_err_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mode      <= w_mode_nxt;
      r_len       <= w_len_nxt;
      r_cnt       <= w_cnt_nxt;
      r_acc       <= w_acc_nxt;
      r_err_valid <= o_chk;
      if (o_chk) r_parity_err <= o_mis;
    end
  end

  // Disable beats a start, and a start beats a bit in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    o_chk       = 1'b0;
    if (!i_parity_en) begin
      w_state_nxt = IDLE;
    end else if (i_rx_frame_start) begin
      w_state_nxt = DATA;
      w_mode_nxt  = parity_mode_e'(i_parity_mode);
      w_len_nxt   = i_len_eff;
      w_cnt_nxt   = '0;
      w_acc_nxt   = 1'b0;
    end else if (i_rx_bit_valid) begin
      case (r_state)
        DATA: begin
          w_acc_nxt = r_acc ^ i_rx_bit;
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == r_len - 1'b1) w_state_nxt = PAR;
        end
        PAR: begin
          o_chk       = 1'b1;
          w_state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  assign o_mis        = i_rx_bit != parity_calc(r_mode, r_acc);
  assign o_parity_err = r_parity_err;
  assign o_err_valid  = r_err_valid;

endmodule

// File: rtl/uart_parity_engine.sv
// UART parity unit: clocked TX parity generator, RX parity checker, error counter.
// Optional UART_PARITY_ERR_CNT_EN builds the saturating error counter.
module uart_parity_engine
  import uart_parity_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1),
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  parity_en,
  input  logic [1:0]            parity_mode,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  data_valid,
  input  logic                  busy,
  input  logic [DATA_WIDTH-1:0] parity_data,
  output logic                  parity_out,
  input  logic                  rx_frame_start,
  input  logic                  rx_bit_valid,
  input  logic                  rx_bit,
  output logic                  parity_err,
  output logic                  err_valid,
  output logic [ERR_CNT_W-1:0]  err_count,
  input  logic                  err_count_clr
);

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_DATA_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);

  logic [LEN_W-1:0]      w_len_eff;
  logic [DATA_WIDTH-1:0] w_tx_bits;
  logic                  w_tx_cap;
  logic                  w_chk, w_mis;
  logic                  r_parity_out;

  assign w_len_eff = (data_len >= MIN_LEN && data_len <= MAX_LEN) ? data_len : MAX_LEN;

  always_comb begin
    w_tx_bits = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      w_tx_bits[i] = parity_data[i] & (i < int'(w_len_eff));
  end

  assign w_tx_cap = parity_en && data_valid && !busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_parity_out <= 1'b0;
    else if (w_tx_cap) r_parity_out <= parity_calc(parity_mode_e'(parity_mode), ^w_tx_bits);
  end

  assign parity_out = r_parity_out;

  uart_parity_rx_chk #(.LEN_W(LEN_W)) u_rx_chk (
    .clk              (clk),
    .rst_n            (rst),
    .i_parity_en      (parity_en),
    .i_parity_mode    (parity_mode),
    .i_len_eff        (w_len_eff),
    .i_rx_frame_start (rx_frame_start),
    .i_rx_bit_valid   (rx_bit_valid),
    .i_rx_bit         (rx_bit),
    .o_chk            (w_chk),
    .o_mis            (w_mis),
    .o_parity_err     (parity_err),
    .o_err_valid      (err_valid)
  );

`ifdef UART_PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] r_err_count;

  // Clear wins over a same-cycle increment; counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 r_err_count <= '0;
    else if (err_count_clr)                   r_err_count <= '0;
    else if (w_chk && w_mis && ~&r_err_count) r_err_count <= r_err_count + 1'b1;
  end

  assign err_count = r_err_count;
`else
  logic w_unused_cnt;
  assign w_unused_cnt = err_count_clr ^ w_chk ^ w_mis;
  assign err_count    = '0;
`endif

endmodule

// File: tb/tb_uart_parity_engine.sv
// Directed bench for uart_parity_engine; RX check results go through a scoreboard queue.
module tb_uart_parity_engine;

`ifdef UART_PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       parity_en = 1'b0;
  logic [1:0] parity_mode = 2'd0;
  logic [3:0] data_len = 4'd8;
  logic       data_valid = 1'b0;
  logic       busy = 1'b0;
  logic [7:0] parity_data = 8'h00;
  logic       parity_out;
  logic       rx_frame_start = 1'b0;
  logic       rx_bit_valid = 1'b0;
  logic       rx_bit = 1'b0;
  logic       parity_err;
  logic       err_valid;
  logic [7:0] err_count;
  logic       err_count_clr = 1'b0;

  int   n_chk = 0;
  int   n_fail = 0;
  int   n_ev = 0;
  int   ev0;
  int   cnt_m = 0;
  logic sb_q[$];

  uart_parity_engine #(.DATA_WIDTH(8), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .parity_en(parity_en), .parity_mode(parity_mode),
    .data_len(data_len), .data_valid(data_valid), .busy(busy),
    .parity_data(parity_data), .parity_out(parity_out),
    .rx_frame_start(rx_frame_start), .rx_bit_valid(rx_bit_valid), .rx_bit(rx_bit),
    .parity_err(parity_err), .err_valid(err_valid), .err_count(err_count),
    .err_count_clr(err_count_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every err_valid pulse must match a queued expectation.
  always @(negedge clk) begin
    if (err_valid === 1'b1) begin
      n_ev++;
      if (sb_q.size() == 0) check("rx_unexpected_ev", 32'd1, 32'd0);
      else                  check("rx_parity_err", {31'd0, parity_err}, {31'd0, sb_q.pop_front()});
    end
  end

  task automatic tx_cap(input logic [7:0] d, input logic [3:0] len, input logic [1:0] mode,
                        input logic bsy, input logic exp, input string tag);
    @(posedge clk); #1;
    parity_data = d; data_len = len; parity_mode = mode; busy = bsy; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0; busy = 1'b0;
    check(tag, {31'd0, parity_out}, {31'd0, exp});
  endtask

  task automatic rx_start(input logic [1:0] mode, input logic [3:0] len);
    @(posedge clk); #1;
    parity_mode = mode; data_len = len; rx_frame_start = 1'b1;
    @(posedge clk); #1;
    rx_frame_start = 1'b0;
  endtask

  task automatic rx_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      rx_bit_valid = 1'b1; rx_bit = d[i];
      @(posedge clk); #1;
    end
    rx_bit_valid = 1'b0;
  endtask

  task automatic rx_frame(input logic [1:0] mode, input logic [7:0] d, input logic [3:0] len,
                          input logic pb, input logic exp_err, input logic clr);
    rx_start(mode, len);
    rx_bits(d, int'(len));
    sb_q.push_back(exp_err);
    rx_bit_valid = 1'b1; rx_bit = pb; err_count_clr = clr;
    @(posedge clk); #1;
    rx_bit_valid = 1'b0; err_count_clr = 1'b0;
    if (CNT_EN) begin
      if (clr) cnt_m = 0;
      else if (exp_err && cnt_m < 255) cnt_m++;
    end
  endtask

  initial begin
    #12;
    check("rst_parity_out", {31'd0, parity_out}, 32'd0);
    check("rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    @(posedge clk); #1 rst = 1'b1; parity_en = 1'b1;

    // TX: A5 has four ones; F1 low five bits 10001; 81 clamped to 8 bits has two ones
    tx_cap(8'hA5, 4'd8, 2'd1, 1'b0, 1'b1, "tx_a5_odd");
    tx_cap(8'hA5, 4'd8, 2'd0, 1'b0, 1'b0, "tx_a5_even");
    tx_cap(8'hF1, 4'd5, 2'd1, 1'b0, 1'b1, "tx_f1_len5_odd");
    tx_cap(8'hF1, 4'd5, 2'd0, 1'b0, 1'b0, "tx_f1_len5_even");
    tx_cap(8'h00, 4'd8, 2'd2, 1'b0, 1'b1, "tx_mark");
    tx_cap(8'h00, 4'd8, 2'd3, 1'b1, 1'b1, "tx_busy_hold");
    tx_cap(8'h81, 4'd3, 2'd0, 1'b0, 1'b0, "tx_len3_clamp");
    tx_cap(8'h07, 4'd12, 2'd0, 1'b0, 1'b1, "tx_len12_clamp");
    tx_cap(8'hFF, 4'd8, 2'd3, 1'b0, 1'b0, "tx_space");
    parity_en = 1'b0;
    tx_cap(8'h01, 4'd8, 2'd0, 1'b0, 1'b0, "tx_en_off_hold");
    parity_en = 1'b1;

    // RX: 0x37 has five ones, so even parity bit is 1
    rx_frame(2'd0, 8'h37, 4'd8, 1'b1, 1'b0, 1'b0);
    check("rx_good_cnt", {24'd0, err_count}, cnt_m);
    rx_frame(2'd0, 8'h37, 4'd8, 1'b0, 1'b1, 1'b0);
    check("rx_bad_cnt", {24'd0, err_count}, cnt_m);
    rx_frame(2'd1, 8'h16, 4'd5, 1'b0, 1'b0, 1'b0);
    rx_frame(2'd2, 8'h00, 4'd8, 1'b0, 1'b1, 1'b0);
    rx_frame(2'd3, 8'hFF, 4'd8, 1'b0, 1'b0, 1'b0);
    check("rx_mode_cnt", {24'd0, err_count}, cnt_m);

    // Restart after 4 bits: only the second frame reports
    @(posedge clk); #1;
    ev0 = n_ev;
    rx_start(2'd0, 4'd8);
    rx_bits(8'hFF, 4);
    rx_frame(2'd0, 8'h37, 4'd8, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rx_restart_ev", n_ev - ev0, 32'd1);

    // Start and bit in the same cycle: the bit is dropped
    @(posedge clk); #1;
    parity_mode = 2'd0; data_len = 4'd8;
    rx_frame_start = 1'b1; rx_bit_valid = 1'b1; rx_bit = 1'b1;
    @(posedge clk); #1;
    rx_frame_start = 1'b0;
    rx_bits(8'h37, 8);
    sb_q.push_back(1'b0);
    rx_bit_valid = 1'b1; rx_bit = 1'b1;
    @(posedge clk); #1 rx_bit_valid = 1'b0;

    // parity_en dropped mid-frame: no report even if bits keep coming
    @(posedge clk); #1;
    ev0 = n_ev;
    rx_start(2'd0, 4'd8);
    rx_bits(8'h37, 3);
    parity_en = 1'b0;
    @(posedge clk); #1 parity_en = 1'b1;
    rx_bits(8'hFF, 6);
    @(posedge clk); #1;
    check("rx_en_drop_ev", n_ev - ev0, 32'd0);

    // Saturation
    for (int k = 0; k < 300; k++) rx_frame(2'd0, 8'h37, 4'd8, 1'b0, 1'b1, 1'b0);
    check("rx_sat_cnt", {24'd0, err_count}, cnt_m);
    rx_frame(2'd0, 8'h37, 4'd8, 1'b0, 1'b1, 1'b1);
    check("rx_clr_cnt", {24'd0, err_count}, cnt_m);
    rx_frame(2'd0, 8'h37, 4'd8, 1'b0, 1'b1, 1'b0);
    check("rx_post_clr_cnt", {24'd0, err_count}, cnt_m);

    // Reset mid-frame (DATA, bit 3), with parity_out/parity_err/err_count nonzero
    tx_cap(8'h00, 4'd8, 2'd2, 1'b0, 1'b1, "tx_mark_pre_rst");
    rx_start(2'd0, 4'd8);
    rx_bit_valid = 1'b1; rx_bit = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    cnt_m = 0;
    check("mid_rst_parity_out", {31'd0, parity_out}, 32'd0);
    check("mid_rst_parity_err", {31'd0, parity_err}, 32'd0);
    check("mid_rst_err_valid", {31'd0, err_valid}, 32'd0);
    check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
    check("mid_rst_state", {30'd0, dut.u_rx_chk.r_state}, 32'd0);
    rx_bit_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    rx_frame(2'd0, 8'h37, 4'd8, 1'b1, 1'b0, 1'b0);
    rx_frame(2'd1, 8'h37, 4'd8, 1'b1, 1'b1, 1'b0);
    check("post_rst_cnt", {24'd0, err_count}, cnt_m);

    @(posedge clk); #1;
    check("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised parity unit for the UART datapath. It replaces the latch-style TX parity generator with a clocked generator that supports configurable data width, runtime data length and four parity modes. It adds a serial RX parity checker with per-frame error reporting. It sits between the frame/serializer FSMs and the shift registers on both TX and RX sides.

## Interface
- DATA_WIDTH, 8, maximum data bits per frame (5..16)
- LEN_W, $clog2(DATA_WIDTH+1), width of length fields (derived, do not override)
- ERR_CNT_W, 8, width of the error counter
- clk  in  1  single clock; all logic is rising-edge triggered
- rst  in  1  reset, asynchronous, active-low
- parity_en  in  1  global parity enable
- parity_mode  in  2  0 even, 1 odd, 2 mark (always 1), 3 space (always 0)
- data_len  in  LEN_W  active data bits per frame
- data_valid  in  1  TX data available
- busy  in  1  TX serializer busy
- parity_data  in  DATA_WIDTH  TX data word, LSB first
- parity_out  out  1  registered TX parity bit, held between captures
- rx_frame_start  in  1  pulse when an RX start bit is validated
- rx_bit_valid  in  1  strobe, one per sampled RX data or parity bit
- rx_bit  in  1  sampled RX bit
- parity_err  out  1  1 = last checked frame failed; held until next check
- err_valid  out  1  one-cycle pulse when a check completes
- err_count  out  ERR_CNT_W  saturating count of parity errors
- err_count_clr  in  1  synchronous clear of err_count

## Operation
- Effective length `len_eff`: equals data_len when 5 ≤ data_len ≤ DATA_WIDTH; otherwise DATA_WIDTH.
- TX capture:
  - Condition: `parity_en && data_valid && !busy`.
  - On a capture, parity_out is computed over bits [len_eff-1:0] using the current parity_mode.
  - With no capture, parity_out holds its value. No latches.
- Parity function:
  - Even: XOR of the bits.
  - Odd: XNOR of the bits.
  - Mark: 1.
  - Space: 0.
- RX checker FSM has three states: IDLE, DATA, PAR.
  - IDLE → DATA on `rx_frame_start && parity_en`. Entering DATA latches parity_mode and len_eff, clears the accumulator, and clears bit_cnt.
  - DATA, on each rx_bit_valid: accumulator ^= rx_bit and bit_cnt++. When bit_cnt reaches len_eff-1 on a valid bit, go to PAR.
  - PAR, on rx_bit_valid:
    - Compare rx_bit against the expected parity for the latched mode.
    - Set parity_err = (mismatch).
    - Pulse err_valid.
    - Return to IDLE.
- rx_frame_start in DATA or PAR restarts the frame (same actions as IDLE → DATA). The aborted frame produces no err_valid.
- parity_en deasserted while in DATA or PAR: return to IDLE with no report.
- rx_frame_start and rx_bit_valid in the same cycle: the start wins and the bit is discarded.

## Timing
- Reset values: parity_out=0, parity_err=0, err_valid=0, err_count=0, FSM=IDLE.
- TX latency: parity_out is valid one cycle after the capture edge.
- RX check: err_valid and parity_err update in the cycle after the parity-bit rx_bit_valid edge.
- err_count increments in that same cycle when there is a mismatch, and saturates at all-ones.
- err_count_clr has priority over a simultaneous increment; the result is 0.
- Reset asserted mid-frame: all state returns immediately (asynchronously) to reset values.

## Configuration
- UART_PARITY_ERR_CNT_EN defined: saturating err_count register and err_count_clr are implemented.
- Not defined: err_count is tied to 0, err_count_clr is ignored, and no counter flops are inferred. The port list is unchanged.

## Structure
- Package uart_parity_pkg holds:
  - parity_mode_e enum (EVEN, ODD, MARK, SPACE)
  - rx_chk_state_e enum (IDLE, DATA, PAR)
  - function `parity_calc(mode, acc)` returning the expected bit
  - constant MIN_DATA_LEN=5
- One sub-module, uart_parity_rx_chk, holds the RX FSM, accumulator and bit counter.
- The top level holds TX capture, len_eff clamping and the error counter.

## Test plan
- TX even parity: data 8'hA5, len 8 → parity_out=0 one cycle after capture. Same data with odd parity → 1.
- TX length and mode:
  - data 8'hF1, len 5 (bits 5'h11) even → parity_out=0.
  - Capture with busy=1 → parity_out unchanged.
  - len=3 clamps to 8.
- RX good frame: 8 bits of 0x37, parity bit 1, even → err_valid pulse, parity_err=0, err_count=0.
- RX bad frame: the same frame with parity bit 0 → parity_err=1 and err_count=1.
  - 300 bad frames → err_count=255 (macro on).
  - err_count_clr concurrent with an error → err_count=0.
- RX restart: rx_frame_start after 4 bits, then a full good frame → exactly one err_valid, with parity_err=0.
- Reset: rst low mid-frame (DATA, bit 3) → all outputs 0 and FSM IDLE. A following frame is checked normally.
